// File: rtl/bus_pkg.sv
// Shared types for the multiplexed bus cycle unit: cycle kinds, T-state codes
// and the S1/S0 status encodings.
package bus_pkg;

    typedef enum logic [2:0] {
        KindFetch = 3'd0,
        KindMemRd = 3'd1,
        KindMemWr = 3'd2,
        KindIoRd  = 3'd3,
        KindIoWr  = 3'd4
    } cycle_kind_e;

    typedef enum logic [2:0] {
        StTi = 3'd0,
        StT1 = 3'd1,
        StT2 = 3'd2,
        StTw = 3'd3,
        StT3 = 3'd4,
        StTh = 3'd5
    } tstate_e;

    // {S1, S0}
    localparam logic [1:0] StatIdle  = 2'b00;
    localparam logic [1:0] StatWrite = 2'b01;
    localparam logic [1:0] StatRead  = 2'b10;
    localparam logic [1:0] StatFetch = 2'b11;

    // Unassigned request codes fall back to a plain memory read.
    function automatic cycle_kind_e decode_kind(input logic [2:0] code);
        case (code)
            3'd0:    return KindFetch;
            3'd2:    return KindMemWr;
            3'd3:    return KindIoRd;
            3'd4:    return KindIoWr;
            default: return KindMemRd;
        endcase
    endfunction

    function automatic logic kind_is_write(input cycle_kind_e kind);
        return (kind == KindMemWr) || (kind == KindIoWr);
    endfunction

    function automatic logic kind_is_io(input cycle_kind_e kind);
        return (kind == KindIoRd) || (kind == KindIoWr);
    endfunction

    function automatic logic [1:0] kind_status(input cycle_kind_e kind);
        case (kind)
            KindFetch:          return StatFetch;
            KindMemWr, KindIoWr: return StatWrite;
            default:            return StatRead;
        endcase
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared on load, counts up while enabled, saturates at
// its maximum and reports when the configured number of waits has elapsed.
module bus_wait_timer #(
    parameter int unsigned WaitW = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             count_i,
    input  logic [WaitW-1:0] limit_i,
    output logic             done_o
);

    localparam logic [WaitW-1:0] CntMax = '1;

    logic [WaitW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q >= limit_i);

endmodule

// File: rtl/bus_cycle_unit.sv
// Multiplexed address/data bus master: runs fetch/read/write cycles through
// T1-T2-TW-T3 with READY wait states and HOLD/HLDA bus release.
module bus_cycle_unit
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WAIT_W = 3
) (
    input  logic                     clock,
    input  logic                     reset_in,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_kind,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [WAIT_W-1:0]        req_wait,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic                     READY,
    input  logic                     HOLD,
    output logic                     HLDA,
    output logic                     ALE,
    output logic                     RDn,
    output logic                     WRn,
    output logic                     IO_Mn,
    output logic                     S0,
    output logic                     S1,
    output logic [DATA_W-1:0]        AD_out,
    output logic                     AD_oe,
    input  logic [DATA_W-1:0]        AD_in,
    output logic [ADDR_W-DATA_W-1:0] ADD,
    output logic                     bus_oe,
    output logic [2:0]               state
);

    tstate_e             state_q, state_d;
    cycle_kind_e         kind_q, kind_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                armed_q;

    logic                ale_q, ale_d;
    logic                rdn_q, rdn_d;
    logic                wrn_q, wrn_d;
    logic                iom_q, iom_d;
    logic [1:0]          stat_q, stat_d;
    logic [DATA_W-1:0]   ad_out_q, ad_out_d;
    logic                ad_oe_q, ad_oe_d;
    logic [ADDR_W-DATA_W-1:0] add_q, add_d;
    logic                bus_oe_q, bus_oe_d;
    logic                hlda_q, hlda_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                accept;
    logic                wait_done;
    logic                active_d;
    logic                data_phase_d;
    logic                write_d;

    // armed_q keeps the unit from accepting on the very first edge after reset.
    assign req_ready = armed_q && !HOLD && ((state_q == StTi) || (state_q == StT3));
    assign accept    = req_valid && req_ready;

    bus_wait_timer #(
        .WaitW (WAIT_W)
    ) u_wait_timer (
        .clk_i   (clock),
        .rst_ni  (reset_in),
        .load_i  (accept),
        .count_i ((state_q == StT2) || (state_q == StTw)),
        .limit_i (wait_q),
        .done_o  (wait_done)
    );

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        unique case (state_q)
            StTi: begin
                if (HOLD) begin
                    state_d = StTh;
                end else if (accept) begin
                    state_d = StT1;
                end
            end
            StT1: state_d = StT2;
            StT2, StTw: state_d = (wait_done && READY) ? StT3 : StTw;
            // HOLD is honoured only once the running cycle has finished.
            StT3: begin
                if (HOLD) begin
                    state_d = StTh;
                end else if (accept) begin
                    state_d = StT1;
                end else begin
                    state_d = StTi;
                end
            end
            StTh: begin
                if (!HOLD) begin
                    state_d = StTi;
                end
            end
            default: state_d = StTi;
        endcase
        if (accept) begin
            kind_d  = decode_kind(req_kind);
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wait_d  = req_wait;
        end
    end

    // Strobes are computed for the state being entered so they leave flops.
    always_comb begin
        active_d     = (state_d == StT1) || (state_d == StT2) ||
                       (state_d == StTw) || (state_d == StT3);
        data_phase_d = (state_d == StT2) || (state_d == StTw) || (state_d == StT3);
        write_d      = kind_is_write(kind_d);

        ale_d    = (state_d == StT1);
        rdn_d    = !(data_phase_d && !write_d);
        wrn_d    = !(data_phase_d && write_d);
        stat_d   = active_d ? kind_status(kind_d) : StatIdle;
        iom_d    = active_d && kind_is_io(kind_d);
        ad_oe_d  = (state_d == StT1) || (data_phase_d && write_d);
        add_d    = active_d ? addr_d[ADDR_W-1:DATA_W] : '0;
        bus_oe_d = (state_d != StTh);
        hlda_d   = (state_d == StTh);

        ad_out_d = '0;
        if (state_d == StT1) begin
            ad_out_d = addr_d[DATA_W-1:0];
        end else if (data_phase_d && write_d) begin
            ad_out_d = wdata_d;
        end

        rsp_valid_d = (state_q == StT3);
        rsp_rdata_d = rsp_rdata_q;
        if ((state_q == StT3) && !kind_is_write(kind_q)) begin
            rsp_rdata_d = AD_in;
        end
    end

    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= StTi;
            kind_q      <= KindFetch;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            armed_q     <= 1'b0;
            ale_q       <= 1'b0;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            iom_q       <= 1'b0;
            stat_q      <= StatIdle;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            add_q       <= '0;
            bus_oe_q    <= 1'b1;
            hlda_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            armed_q     <= 1'b1;
            ale_q       <= ale_d;
            rdn_q       <= rdn_d;
            wrn_q       <= wrn_d;
            iom_q       <= iom_d;
            stat_q      <= stat_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            add_q       <= add_d;
            bus_oe_q    <= bus_oe_d;
            hlda_q      <= hlda_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign state     = state_q;
    assign ALE       = ale_q;
    assign RDn       = rdn_q;
    assign WRn       = wrn_q;
    assign IO_Mn     = iom_q;
    assign S1        = stat_q[1];
    assign S0        = stat_q[0];
    assign AD_out    = ad_out_q;
    assign AD_oe     = ad_oe_q;
    assign ADD       = add_q;
    assign bus_oe    = bus_oe_q;
    assign HLDA      = hlda_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit: a driver pushes expected completions,
// a monitor checks bus strobes every cycle and pops on each rsp_valid.
module tb_bus_cycle_unit;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 3;

    logic              clock = 1'b0;
    logic              reset_in = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_kind = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [WAIT_W-1:0] req_wait = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              READY = 1'b1;
    logic              HOLD = 1'b0;
    logic              HLDA, ALE, RDn, WRn, IO_Mn, S0, S1, AD_oe, bus_oe;
    logic [DATA_W-1:0] AD_out;
    logic [DATA_W-1:0] AD_in = '0;
    logic [ADDR_W-DATA_W-1:0] ADD;
    logic [2:0]        state;

    bus_cycle_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WAIT_W (WAIT_W)
    ) dut (
        .clock     (clock),
        .reset_in  (reset_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wait  (req_wait),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .READY     (READY),
        .HOLD      (HOLD),
        .HLDA      (HLDA),
        .ALE       (ALE),
        .RDn       (RDn),
        .WRn       (WRn),
        .IO_Mn     (IO_Mn),
        .S0        (S0),
        .S1        (S1),
        .AD_out    (AD_out),
        .AD_oe     (AD_oe),
        .AD_in     (AD_in),
        .ADD       (ADD),
        .bus_oe    (bus_oe),
        .state     (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int addr;
        int wdata;
        int rdata;
        int lat;
        int tw;
        int stamp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_rdata = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic bit is_write(input int k);
        return (k == 2) || (k == 4);
    endfunction

    function automatic bit is_io(input int k);
        return (k == 3) || (k == 4);
    endfunction

    function automatic int exp_status(input int k);
        if (k == 0) return 3;
        if (is_write(k)) return 1;
        return 2;
    endfunction

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Monitor: every cycle, compare bus pins against the oldest outstanding request.
    initial begin : monitor
        int   tw_seen;
        exp_t e;
        exp_t cur;
        tw_seen = 0;
        forever begin
            @(posedge clock);
            #2;
            if (!reset_in) begin
                tw_seen = 0;
                continue;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_latency", cyc - e.stamp, e.lat);
                    chk("tw_cycles", tw_seen, e.tw);
                end
                tw_seen = 0;
            end
            case (state)
                3'd0: begin
                    chk("ti_ale", ALE, 0);
                    chk("ti_rdn", RDn, 1);
                    chk("ti_wrn", WRn, 1);
                    chk("ti_status", {S1, S0}, 0);
                    chk("ti_io_mn", IO_Mn, 0);
                    chk("ti_ad_oe", AD_oe, 0);
                    chk("ti_bus_oe", bus_oe, 1);
                    chk("ti_hlda", HLDA, 0);
                end
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    if (sb.size() == 0) begin
                        chk("active_without_request", 1, 0);
                    end else begin
                        cur = sb[0];
                        chk("ale_only_t1", ALE, (state == 3'd1));
                        chk("status", {S1, S0}, exp_status(cur.kind));
                        chk("io_mn", IO_Mn, is_io(cur.kind));
                        chk("add_high", ADD, (cur.addr >> DATA_W) & 'hFF);
                        chk("bus_oe", bus_oe, 1);
                        chk("hlda", HLDA, 0);
                        if (state == 3'd1) begin
                            chk("t1_ad_out", AD_out, cur.addr & 'hFF);
                            chk("t1_ad_oe", AD_oe, 1);
                            chk("t1_rdn", RDn, 1);
                            chk("t1_wrn", WRn, 1);
                        end else begin
                            chk("data_rdn", RDn, is_write(cur.kind));
                            chk("data_wrn", WRn, !is_write(cur.kind));
                            chk("data_ad_oe", AD_oe, is_write(cur.kind));
                            if (is_write(cur.kind)) chk("data_ad_out", AD_out, cur.wdata);
                        end
                        if (state == 3'd3) tw_seen++;
                    end
                end
                3'd5: begin
                    chk("th_hlda", HLDA, 1);
                    chk("th_bus_oe", bus_oe, 0);
                    chk("th_ad_oe", AD_oe, 0);
                    chk("th_rdn", RDn, 1);
                    chk("th_wrn", WRn, 1);
                    chk("th_ale", ALE, 0);
                end
                default: chk("state_code_range", state, 0);
            endcase
        end
    end

    task automatic offer(input int kind, input int addr, input int wdata, input int wt);
        req_valid = 1'b1;
        req_kind  = 3'(kind);
        req_addr  = 16'(addr);
        req_wdata = 8'(wdata);
        req_wait  = 3'(wt);
    endtask

    // Called at a negedge with a request offered; returns after the accepting edge.
    task automatic wait_accept(output int stamp, output int tries);
        bit got;
        got   = 1'b0;
        tries = 0;
        while (!got) begin
            #1;
            got = req_ready;
            @(posedge clock);
            #1;
            if (!got) begin
                tries++;
                if (tries > 40) begin
                    chk("accept_timeout", 0, 1);
                    finish_sim();
                end
                @(negedge clock);
            end
        end
        stamp = cyc;
    endtask

    // Runs one request; returns at the negedge inside its T3 cycle.
    task automatic run_txn(input int kind, input int addr, input int wdata, input int wt,
                           input int r, input int adin, input bit hold_t2,
                           output int tries);
        int   stamp;
        int   n;
        exp_t e;
        wait_accept(stamp, tries);
        n = (wt > r) ? wt : r;
        if (!is_write(kind)) last_rdata = adin & 'hFF;
        e.kind  = kind;
        e.addr  = addr;
        e.wdata = wdata & 'hFF;
        e.rdata = last_rdata;
        e.lat   = 3 + n;
        e.tw    = n;
        e.stamp = stamp;
        sb.push_back(e);
        @(negedge clock);
        req_valid = 1'b0;
        AD_in     = 8'(adin);
        READY     = (r == 0);
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clock);
            READY = (k >= r);
            if (hold_t2 && (k == 0)) HOLD = 1'b1;
        end
    endtask

    // Entered at the negedge inside T3 with HOLD high.
    task automatic hold_seq(input int extra);
        @(posedge clock);
        #1;
        chk("hold_state_th", state, 5);
        chk("hold_hlda", HLDA, 1);
        chk("hold_bus_oe", bus_oe, 0);
        chk("hold_req_ready", req_ready, 0);
        repeat (extra) @(posedge clock);
        @(negedge clock);
        HOLD = 1'b0;
        @(posedge clock);
        #1;
        chk("hold_release_ti", state, 0);
    endtask

    initial begin : watchdog
        #400000;
        chk("global_timeout", 0, 1);
        finish_sim();
    end

    initial begin : driver
        int   tries;
        int   stamp;
        bit   b2b;
        bit   hold;
        int   kind, addr, wdata, wt, r, adin;
        exp_t e;

        #1 reset_in = 1'b0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_ale", ALE, 0);
        chk("rst_rdn", RDn, 1);
        chk("rst_wrn", WRn, 1);
        chk("rst_status", {S1, S0}, 0);
        chk("rst_io_mn", IO_Mn, 0);
        chk("rst_ad_oe", AD_oe, 0);
        chk("rst_ad_out", AD_out, 0);
        chk("rst_add", ADD, 0);
        chk("rst_bus_oe", bus_oe, 1);
        chk("rst_hlda", HLDA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 0);
        repeat (2) @(negedge clock);
        reset_in = 1'b1;
        repeat (2) @(negedge clock);

        // Mem read 0x2050, no waits, AD_in=0xA5.
        offer(1, 'h2050, 0, 0);
        run_txn(1, 'h2050, 0, 0, 0, 'hA5, 1'b0, tries);
        @(negedge clock);
        // IO write 0x0042 <= 0x3C with two wait states.
        offer(4, 'h0042, 'h3C, 2);
        run_txn(4, 'h0042, 'h3C, 2, 0, 'h00, 1'b0, tries);
        @(negedge clock);
        // Mem read, READY low for three cycles from T2.
        offer(1, 'h1234, 0, 0);
        run_txn(1, 'h1234, 0, 0, 3, 'h5A, 1'b0, tries);
        @(negedge clock);
        // Back-to-back fetches: the second is offered during T3.
        offer(0, 'h0100, 0, 0);
        run_txn(0, 'h0100, 0, 0, 0, 'h11, 1'b0, tries);
        offer(0, 'h0101, 0, 0);
        run_txn(0, 'h0101, 0, 0, 0, 'h22, 1'b0, tries);
        chk("b2b_accepted_in_t3", tries, 0);
        @(negedge clock);
        // Maximum wait with READY low far past the counter's top value.
        offer(5, 'h3000, 0, 7);
        run_txn(5, 'h3000, 0, 7, 12, 'h77, 1'b0, tries);
        @(negedge clock);
        // HOLD raised in T2 of a write.
        offer(2, 'h4000, 'h99, 0);
        run_txn(2, 'h4000, 'h99, 0, 0, 'h00, 1'b1, tries);
        hold_seq(2);

        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 7);
            addr  = $urandom_range(0, 'hFFFF);
            wdata = $urandom_range(0, 'hFF);
            adin  = $urandom_range(0, 'hFF);
            wt    = $urandom_range(0, 7);
            r     = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 10);
            hold  = ($urandom_range(0, 4) == 0);
            if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clock);
            offer(kind, addr, wdata, wt);
            run_txn(kind, addr, wdata, wt, r, adin, hold, tries);
            if (b2b) chk("rand_b2b_accepted_in_t3", tries, 0);
            if (hold) begin
                hold_seq($urandom_range(0, 3));
                b2b = 1'b0;
            end else begin
                b2b = $urandom_range(0, 1);
            end
        end

        // Reset in the middle of a waited read.
        @(negedge clock);
        offer(1, 'h5566, 0, 7);
        wait_accept(stamp, tries);
        e.kind = 1; e.addr = 'h5566; e.wdata = 0; e.rdata = 0;
        e.lat = 10; e.tw = 7; e.stamp = stamp;
        sb.push_back(e);
        @(negedge clock);
        req_valid = 1'b0;
        READY     = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        chk("pre_reset_in_tw", state, 3);
        chk("pre_reset_rdn_low", RDn, 0);
        reset_in = 1'b0;
        sb.delete();
        last_rdata = 0;
        #1;
        chk("reset_rdn_async", RDn, 1);
        chk("reset_state_async", state, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clock);
        #2 reset_in = 1'b1;
        #1;
        chk("release_req_ready_low", req_ready, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("release_req_ready_2nd_edge", req_ready, 1);

        // Recovery: a read, then a write that must leave rsp_rdata alone.
        @(negedge clock);
        offer(3, 'h00F0, 0, 1);
        run_txn(3, 'h00F0, 0, 1, 0, 'hC3, 1'b0, tries);
        @(negedge clock);
        offer(2, 'h8001, 'h4E, 0);
        run_txn(2, 'h8001, 'h4E, 0, 2, 'h00, 1'b0, tries);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        finish_sim();
    end

endmodule
